// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and defaults for the two-port RAM arbiter.
//   arb_state_t  : access sequencer states (IDLE -> ADDR -> [WAIT] -> DONE)
//   req_idx_t    : requester index (0 = CPU core bus, 1 = loader/debug port)
//   RD_LAT_DEFAULT / TIMEOUT_DEFAULT : default parameter values
//   rr_pick()    : round-robin winner selection between the two requesters
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef logic req_idx_t;

    localparam int RD_LAT_DEFAULT  = 1;
    localparam int TIMEOUT_DEFAULT = 16;

    // Winner for a new grant: a lone requester always wins; on a tie the
    // port that was not served last wins.
    function automatic req_idx_t rr_pick(input logic     r0,
                                         input logic     r1,
                                         input req_idx_t last_grant);
        if (r0 && r1) begin
            return ~last_grant;
        end else if (r1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/ram_arb_timer.sv
// ---------------------------------------------------------------------------
// ram_arb_timer
// Lock-tenure counter. Counts the accesses the current owner has completed
// and kept the grant after; saturates so it never wraps.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the tenure (grant is being given up)
//   inc        : one more access completed with the grant retained
//   expire     : the access now finishing is the LIMIT-th of this tenure
// ---------------------------------------------------------------------------
module ram_arb_timer
    import ram_arb_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((LIMIT > 1) ? (LIMIT - 1) : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q holds the accesses already completed in this tenure, so the
    // access currently in DONE is number count_q+1; expiry therefore fires
    // once count_q has reached LIMIT-1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single RAM port between requester 0 (CPU core bus) and
// requester 1 (program loader / debug port). Requests use a req/ack
// handshake, new grants are round-robin, and an owner holding lock keeps
// the port for back-to-back accesses without an IDLE cycle.
//
// Optional feature macro: RAM_ARB_TIMEOUT_EN
//   defined   : a locked owner is forced off after TIMEOUT accesses when the
//               other port is waiting; 'timeout' pulses in that DONE cycle.
//   undefined : lock is honoured indefinitely, 'timeout' is tied low.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN/weN/lockN        : request, write(1)/read(0), keep grant afterwards
//   addrN/wdataN          : access address / write data (stable until ack)
//   gntN                  : requester N owns the RAM port (ADDR..DONE)
//   ackN                  : one-cycle access-complete pulse
//   rdataN                : read data, valid with ack, held until next ack
//   ram_addr/ram_data/ram_we : registered RAM address, write data, write en
//   ram_out               : RAM read data, valid RD_LAT cycles into access
//   timeout               : one-cycle pulse on forced lock revocation
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = RD_LAT_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_out,
    output logic              timeout
);

    // WAIT lasts RD_LAT-1 cycles; the counter runs 0..RD_LAT-2.
    localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    arb_state_t        state_q, state_d;
    req_idx_t          owner_q, owner_d;
    req_idx_t          last_q, last_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;

    req_idx_t          pick;
    req_idx_t          src_idx;
    logic              src_we;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;
    logic              own_req;
    logic              own_lock;
    logic              keep;
    logic              force_release;
    logic              launch;
    logic              capture;

    assign pick = rr_pick(req0, req1, last_q);

    // In IDLE the new access comes from the round-robin winner; in DONE a
    // locked continuation comes from the current owner.
    assign src_idx   = (state_q == IDLE) ? pick : owner_q;
    assign src_we    = src_idx ? we1    : we0;
    assign src_addr  = src_idx ? addr1  : addr0;
    assign src_wdata = src_idx ? wdata1 : wdata0;

    assign own_req  = owner_q ? req1  : req0;
    assign own_lock = owner_q ? lock1 : lock0;
    assign keep     = own_lock && own_req;

`ifdef RAM_ARB_TIMEOUT_EN
    logic other_req;
    logic tenure_inc;
    logic tenure_clr;
    logic tenure_expire;

    assign other_req     = owner_q ? req0 : req1;
    assign force_release = keep && other_req && tenure_expire;

    // Every loss of the grant passes through DONE -> IDLE, so clearing there
    // restarts the tenure whenever ownership can change.
    assign tenure_inc = (state_q == DONE) && keep && !force_release;
    assign tenure_clr = (state_q == DONE) && !(keep && !force_release);

    ram_arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tenure_clr),
        .inc    (tenure_inc),
        .expire (tenure_expire)
    );

    assign timeout = (state_q == DONE) && force_release;
`else
    assign force_release = 1'b0;
    // TIMEOUT is always positive, so this ties the pulse low.
    assign timeout       = (TIMEOUT < 0);
`endif

    // Sequencer next-state. launch loads a new access onto the RAM
    // registers; capture latches ram_out into the owner's read register.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        wait_cnt_d = wait_cnt_q;
        launch     = 1'b0;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    launch  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ram_we_q) begin
                    state_d = DONE;
                end else if (RD_LAT == 1) begin
                    // Single-cycle RAM: data is already valid this cycle.
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = 2'd0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            DONE: begin
                last_d = owner_q;
                if (keep && !force_release) begin
                    launch  = 1'b1;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            ram_addr_d = src_addr;
            ram_data_d = src_wdata;
            ram_we_d   = src_we;
        end

        if (capture) begin
            if (owner_q) begin
                rdata1_d = ram_out;
            end else begin
                rdata0_d = ram_out;
            end
        end
    end

    // State and RAM-side registers; reset aborts any access in flight and
    // drops ram_we without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign gnt0     = (state_q != IDLE) && (owner_q == 1'b0);
    assign gnt1     = (state_q != IDLE) && (owner_q == 1'b1);
    assign ack0     = (state_q == DONE) && (owner_q == 1'b0);
    assign ack1     = (state_q == DONE) && (owner_q == 1'b1);
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed self-checking bench for ram_arbiter (RD_LAT = 2, TIMEOUT = 3)
// with a small RAM model: registered read, so data for an address shown in
// one cycle appears on ram_out in the next. Unwritten locations read back
// as 0xC0 | address.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic       lock0 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, ack0, ack1, ram_we, timeout;
    logic [7:0] rdata0, rdata1, ram_addr, ram_data;
    logic [7:0] ram_out = '0;

    logic [7:0]   mem [0:255];
    logic [255:0] written = '0;

    int compared = 0;
    int mismatched = 0;
    int bothGnt = 0;
    int lockViolations = 0;
    int monLock = 0;
    int monTo = 0;

    ram_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .RD_LAT  (2),
        .TIMEOUT (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .lock0    (lock0),
        .lock1    (lock1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_out  (ram_out),
        .timeout  (timeout)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_data;
            written[ram_addr] <= 1'b1;
        end
        ram_out <= written[ram_addr] ? mem[ram_addr] : (8'hC0 | ram_addr);
    end

    // Grant monitors: never two grants, and no foreign grant while a
    // monitored tenure is running.
    always @(negedge clk) begin
        if (gnt0 && gnt1) bothGnt++;
        if (monLock != 0 && gnt0) lockViolations++;
        if (monTo != 0 && gnt1) lockViolations++;
    end

    // Last-resort guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we, input logic lock,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            req0 = req; we0 = we; lock0 = lock; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = req; we1 = we; lock1 = lock; addr1 = addr; wdata1 = wdata;
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Steps negedges until the port's ack is seen or the budget runs out;
    // the final ack value is itself a comparison.
    task automatic waitAck(input int port, input int maxCycles, input string tag, output int cycles);
        logic a;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            a = (port == 0) ? ack0 : ack1;
        end while (!a && cycles < maxCycles);
        checkOutput({tag, "_ack"}, a, 1);
    endtask

    // Both ports issue a write in the same cycle; expFirst must be served
    // first, then one IDLE cycle, then the other port.
    task automatic tieRound(input int expFirst, input string tag);
        int cyc;
        int second;
        second = 1 - expFirst;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h5A);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'h31, 8'h6B);
        nextCycle();
        checkOutput({tag, "_gnt_first"}, {gnt0, gnt1}, (expFirst == 0) ? 2'b10 : 2'b01);
        waitAck(expFirst, 4, {tag, "_first"}, cyc);
        checkOutput({tag, "_first_lat"}, cyc, 1);
        applyStimulus(expFirst, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        checkOutput({tag, "_idle_gap"}, {gnt0, gnt1}, 2'b00);
        nextCycle();
        checkOutput({tag, "_gnt_second"}, {gnt0, gnt1}, (second == 0) ? 2'b10 : 2'b01);
        waitAck(second, 4, {tag, "_second"}, cyc);
        applyStimulus(second, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
    endtask

    initial begin
        int cyc;
        int nAck;
`ifdef RAM_ARB_TIMEOUT_EN
        nAck = 3;
`else
        nAck = 4;
`endif

        // Reset state: every output low.
        nextCycle();
        checkOutput("reset_outputs",
                    {gnt0, gnt1, ack0, ack1, ram_we, timeout, ram_addr, ram_data, rdata0, rdata1},
                    38'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("idle_after_reset", {gnt0, gnt1, ack0, ack1}, 4'b0000);

        // Round-robin: first tie to port 0, then port 0 again after port 1.
        tieRound(0, "tieA");
        tieRound(0, "tieB");

        // Write 0xA5 to 0x10 from port 0.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
        nextCycle();
        checkOutput("wr_ram_we", ram_we, 1);
        checkOutput("wr_ram_addr", ram_addr, 8'h10);
        checkOutput("wr_ram_data", ram_data, 8'hA5);
        checkOutput("wr_gnt_ack", {gnt0, ack0}, 2'b10);
        nextCycle();
        checkOutput("wr_ack0", ack0, 1);
        checkOutput("wr_we_drop", ram_we, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("wr_release", {gnt0, ack0}, 2'b00);

        // Read it back: ack at t+2+RD_LAT-1 = 3 negedges after drive.
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        waitAck(0, 8, "rd0", cyc);
        checkOutput("rd0_latency", cyc, 3);
        checkOutput("rd0_data", rdata0, 8'hA5);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        checkOutput("rd0_hold", {ack0, rdata0}, {1'b0, 8'hA5});

        // Port 0 was served last, so this tie goes to port 1.
        tieRound(1, "tieC");

        // Port 1 locked: four reads of 0x00..0x03, 3 cycles apart.
        monLock = 1;
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            waitAck(1, 8, $sformatf("lock_rd%0d", i), cyc);
            checkOutput($sformatf("lock_rd%0d_spacing", i), cyc, 3);
            checkOutput($sformatf("lock_rd%0d_data", i), rdata1, 8'hC0 | 8'(i));
            if (i < 3) applyStimulus(1, 1'b1, 1'b0, 1'b1, 8'(i + 1), 8'h00);
            else       applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        nextCycle();
        monLock = 0;
        checkOutput("lock_gnt0_never", lockViolations, 0);
        checkOutput("lock_released", {gnt0, gnt1}, 2'b00);

        // Port 0 locked writes while port 1 waits for a read of 0x20.
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h11);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        monTo = 1;
        for (int n = 1; n <= nAck; n++) begin
            waitAck(0, 4, $sformatf("to_wr%0d", n), cyc);
            checkOutput($sformatf("to_wr%0d_spacing", n), cyc, (n == 1) ? 1 : 2);
`ifdef RAM_ARB_TIMEOUT_EN
            checkOutput($sformatf("to_pulse%0d", n), timeout, (n == 3) ? 1 : 0);
            applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'(8'h20 + n), 8'(8'h11 + n));
`else
            checkOutput($sformatf("to_pulse%0d", n), timeout, 0);
            if (n < nAck) applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'(8'h20 + n), 8'(8'h11 + n));
            else          applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`endif
        end
        monTo = 0;
        checkOutput("to_gnt1_held_off", lockViolations, 0);
        nextCycle();
        checkOutput("to_idle", {gnt0, gnt1, timeout}, 3'b000);
        nextCycle();
        checkOutput("to_gnt1_next", {gnt0, gnt1}, 2'b01);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        waitAck(1, 8, "to_rd1", cyc);
        checkOutput("to_rd1_latency", cyc, 2);
        checkOutput("to_rd1_data", rdata1, 8'h11);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        nextCycle();

        // Reset during a write's ADDR cycle: ram_we drops without a clock.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h77);
        nextCycle();
        checkOutput("rst_wr_we_before", ram_we, 1);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_wr_async", {ram_we, gnt0, ram_addr}, 10'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Reset during WAIT of a port 1 read: everything clears at once.
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        nextCycle();
        nextCycle();
        checkOutput("rst_rd_in_wait", {gnt1, ack1}, 2'b10);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_rd_async",
                       {gnt0, gnt1, ack0, ack1, ram_we, timeout, ram_addr, ram_data, rdata0, rdata1},
                       38'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            if (ack0 || ack1 || gnt0 || gnt1) cyc++;
        end
        checkOutput("rst_no_ack_after", cyc, 0);

        // last is back to 1, so the first tie goes to port 0 again.
        tieRound(0, "tieD");

        checkOutput("never_two_grants", bothGnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
